data_bus_if: RTL
================

// Module: data_bus_if
// PURPOSE
//  Downstream of the memory stage: turns its per-cycle data-memory request (ce/we/addr/sel/data)
//  into a Wishbone B4 classic master cycle and returns read data as the memory stage's mem_data_in.
//  Holds the pipeline via stall_req_o until the slave acks.
//  Buffers the read word while the pipeline is stalled by another source, and drops the access on flush.
// PARAMETERS
//  ADDR_W          32   address width (cpu and Wishbone)
//  DATA_W          32   data width; sel width is DATA_W/8
//  TIMEOUT_CYCLES  255  BUSY cycles without ack before abort (used only with DBUS_TIMEOUT_EN)
// PORTS
//  clk            in   1         clock; all state changes on rising edge
//  rst            in   1         reset, asynchronous, active-low
//  stall_i        in   6         pipeline stall vector from ctrl ([0]=pc .. [5]=wb)
//  flush_i        in   1         pipeline flush (exception)
//  cpu_ce_i       in   1         memory-stage request valid
//  cpu_we_i       in   1         1=write, 0=read
//  cpu_addr_i     in   ADDR_W    byte address (already word-aligned where required)
//  cpu_sel_i      in   DATA_W/8  byte lanes, bit3 = bits[31:24]
//  cpu_data_i     in   DATA_W    write data
//  cpu_data_o     out  DATA_W    read data to memory stage
//  stall_req_o    out  1         request to ctrl to stall pipeline
//  bus_err_o      out  1         one-cycle pulse on timeout abort (tied 0 without macro)
//  wb_adr_o/wb_dat_o  out  ADDR_W/DATA_W   Wishbone address / write data
//  wb_sel_o       out  DATA_W/8  Wishbone byte select
//  wb_we_o, wb_stb_o, wb_cyc_o  out  1  Wishbone controls
//  wb_dat_i       in   DATA_W    Wishbone read data
//  wb_ack_i       in   1         Wishbone ack
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; rd_buf=0; all wb_* outputs 0; bus_err_o=0.
//  FSM states: IDLE, BUSY, WAIT_STALL.
//  IDLE: on cpu_ce_i=1 & flush_i=0, register wb_adr/dat/sel/we from cpu_*, set stb=cyc=1 -> BUSY.
//   stall_req_o=1 combinationally in that same cycle.
//   cpu_data_o=0.
//  BUSY: wb_* held stable. stall_req_o = ~wb_ack_i.
//   On wb_ack_i: cpu_data_o=wb_dat_i in the ack cycle; rd_buf<=wb_dat_i; stb/cyc/we/sel<=0.
//   Next state is WAIT_STALL if stall_i!=0, else IDLE.
//  WAIT_STALL: cpu_data_o=rd_buf; stall_req_o=0; no new cycle issued although cpu_ce_i stays 1.
//   -> IDLE when stall_i==0.
//  flush_i=1 in any state: stb/cyc<=0 next edge; state->IDLE; rd_buf unchanged; stall_req_o=0.
//   Flush wins over a simultaneous ack and over a new request in IDLE.
//  Minimum latency is 2 cycles (issue, ack). Writes follow the same path; cpu_data_o is don't-care.
//  Back-to-back: a request seen in IDLE the cycle after return is a new access.
//  Reset mid-cycle drops cyc/stb immediately.
// CONFIGURATION
//  DBUS_TIMEOUT_EN defined:
//   Counter cleared on entry to BUSY, increments each BUSY cycle without ack.
//   At TIMEOUT_CYCLES it aborts: stb/cyc<=0, bus_err_o=1 for one cycle, cpu_data_o=0, stall_req_o=0 that cycle.
//   Next state is taken as for an ack; rd_buf<=0.
//  DBUS_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; bus_err_o=0.
// STRUCTURE
//  defines.v gains: DBUS_IDLE/DBUS_BUSY/DBUS_WAIT_STALL state codes, Wishbone width macros,
//   and the existing RstEnable/ChipEnable/ZeroWord constants.
//  Single module with one FSM and one output mux; no sub-module.
// TESTING
//  1. Read 0x0000_0010, slave acks on 3rd BUSY cycle with 0xCAFE_F00D:
//     stall_req_o high 3 cycles; cpu_data_o=0xCAFE_F00D in ack cycle; cyc low next.
//  2. Write sel=4'b0011, data 0x1234_5678, immediate ack:
//     wb_we_o=1, wb_sel_o=0011 for one cycle; stall_req_o high 1 cycle.
//  3. Read acked while stall_i=6'b001111:
//     WAIT_STALL; cpu_data_o holds ack data until stall_i=0; no second stb.
//  4. flush_i asserted in the same cycle as wb_ack_i:
//     cyc/stb drop; state IDLE; stall_req_o=0; rd_buf unchanged.
//  5. rst pulled low mid-BUSY: wb_cyc_o/wb_stb_o go 0 without a clock edge; IDLE after release.
//  6. DBUS_TIMEOUT_EN with TIMEOUT_CYCLES=4, slave never acks:
//     abort after 4 BUSY cycles; bus_err_o pulses once; cpu_data_o=0.

Source files
------------

// File: rtl/data_bus_if_pkg.sv
// rtl/data_bus_if_pkg.sv - state encoding and helpers shared by the data bus interface
package data_bus_if_pkg;

  typedef enum logic [1:0] {
    DBUS_IDLE       = 2'd0,
    DBUS_BUSY       = 2'd1,
    DBUS_WAIT_STALL = 2'd2
  } dbus_state_e;

  // Width of a counter that must hold 0 .. limit-1.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/data_bus_if.sv
// rtl/data_bus_if.sv - memory-stage data request to Wishbone B4 classic master bridge
// Optional BUSY timeout abort is compiled in with DBUS_TIMEOUT_EN.
module data_bus_if
  import data_bus_if_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall_i,
  input  logic                  flush_i,
  input  logic                  cpu_ce_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_W-1:0]     cpu_addr_i,
  input  logic [DATA_W/8-1:0]   cpu_sel_i,
  input  logic [DATA_W-1:0]     cpu_data_i,
  output logic [DATA_W-1:0]     cpu_data_o,
  output logic                  stall_req_o,
  output logic                  bus_err_o,
  output logic [ADDR_W-1:0]     wb_adr_o,
  output logic [DATA_W-1:0]     wb_dat_o,
  output logic [DATA_W/8-1:0]   wb_sel_o,
  output logic                  wb_we_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o,
  input  logic [DATA_W-1:0]     wb_dat_i,
  input  logic                  wb_ack_i
);

  dbus_state_e       state, state_nxt;
  logic [DATA_W-1:0] rd_buf;
  logic              accept;
  logic              done;
  logic              abort;

  assign accept = (state == DBUS_IDLE) && cpu_ce_i && !flush_i;

`ifdef DBUS_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] to_cnt;

  // Held at zero outside BUSY, so every new access starts a fresh count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state != DBUS_BUSY) begin
      to_cnt <= '0;
    end else if (!wb_ack_i) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  assign abort = (state == DBUS_BUSY) && !wb_ack_i && !flush_i &&
                 (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign abort = 1'b0;
`endif

  assign done = (state == DBUS_BUSY) && !flush_i && (wb_ack_i || abort);

  always_comb begin
    state_nxt   = state;
    stall_req_o = 1'b0;
    cpu_data_o  = '0;
    bus_err_o   = abort;
    case (state)
      DBUS_IDLE: begin
        if (accept) begin
          state_nxt   = DBUS_BUSY;
          stall_req_o = 1'b1;
        end
      end
      DBUS_BUSY: begin
        if (flush_i) begin
          state_nxt = DBUS_IDLE;
        end else if (wb_ack_i || abort) begin
          state_nxt = (stall_i != '0) ? DBUS_WAIT_STALL : DBUS_IDLE;
          if (wb_ack_i) cpu_data_o = wb_dat_i;
        end else begin
          stall_req_o = 1'b1;
        end
      end
      DBUS_WAIT_STALL: begin
        // Read word is replayed until the other stall source releases.
        cpu_data_o = rd_buf;
        if (flush_i || stall_i == '0) state_nxt = DBUS_IDLE;
      end
      default: state_nxt = DBUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DBUS_IDLE;
      rd_buf   <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wb_adr_o <= cpu_addr_i;
        wb_dat_o <= cpu_data_i;
        wb_sel_o <= cpu_sel_i;
        wb_we_o  <= cpu_we_i;
        wb_stb_o <= 1'b1;
        wb_cyc_o <= 1'b1;
      end else if (state == DBUS_BUSY && (flush_i || wb_ack_i || abort)) begin
        wb_sel_o <= '0;
        wb_we_o  <= 1'b0;
        wb_stb_o <= 1'b0;
        wb_cyc_o <= 1'b0;
      end
      if (done) rd_buf <= abort ? '0 : wb_dat_i;
    end
  end

endmodule
